mul4_share_ctrl: RTL and testbench
==================================

// Module: mul4_share_ctrl
// PURPOSE
//  Shares one registered 4x4 signed multiplier (7-bit product, 1-cycle en-gated register) among N_REQ requesters.
//  - Round-robin arbitration of operand requests.
//  - Operands are captured, then the multiplier enable is sequenced.
//  - The product is returned with the requester ID over a valid/ready response channel.
//  - Sits between DSP-side clients and the shared multiplier datapath.
// PARAMETERS
//  N_REQ    4   number of requesters (2..8)
//  ID_W     2   width of rsp_id, = clog2(N_REQ)
//  CNT_W    16  width of the completed-operation counter
// PORTS
//  clk        in   1          clock
//  rst_n      in   1          asynchronous, active-low reset
//  req_valid  in   N_REQ      per-requester request valid
//  req_a      in   4*N_REQ    signed multiplicand, requester i at [4i+3:4i]
//  req_b      in   4*N_REQ    signed multiplier, requester i at [4i+3:4i]
//  req_ready  out  N_REQ      one-hot accept; request i is taken when req_valid[i] & req_ready[i]
//  rsp_valid  out  1          response valid
//  rsp_ready  in   1          response consumer ready
//  rsp_id     out  ID_W       index of the requester that owns rsp_p
//  rsp_p      out  7          signed product (multiplier register output)
//  rsp_ovf    out  1          high when the operands were -8 and -8 (true result 64 is not representable; rsp_p = -64)
//  busy       out  1          high in every state except IDLE
//  op_cnt     out  CNT_W      completed responses, saturating at all-ones
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE; all of the following are 0:
//   - req_ready, rsp_valid, rsp_id, rsp_ovf, busy, op_cnt, rr pointer, operand regs, mul_en.
//   - The multiplier register also clears, so rsp_p=0.
//  Reset mid-operation drops the in-flight request and its response. Requesters re-present after reset.
//  States:
//   IDLE: if |req_valid:
//     - grant = first set bit at or after rr_ptr (wrapping) -> req_ready[grant]=1 this cycle (combinational from req_valid).
//     - Latch a, b, id and ovf flag; rr_ptr <= grant+1 mod N_REQ; go to CALC.
//   CALC: mul_en=1 for exactly one cycle; multiplier inputs = latched operands; go to RESP.
//   RESP: rsp_valid=1. mul_en=0, so rsp_p/rsp_id/rsp_ovf stay stable while rsp_ready=0.
//     - On rsp_ready: op_cnt++ (saturating).
//       - If |req_valid: arbitrate as in IDLE in the same cycle and go to CALC (back-to-back).
//       - Otherwise go to IDLE.
//  Latency: accept cycle -> rsp_valid two cycles later. Peak throughput: 1 product per 2 cycles.
//  Handshake rules:
//   - Requesters hold req_valid, a and b stable until they see req_ready.
//   - req_ready is never high in CALC, or in RESP without rsp_ready.
//   - At most one req_ready bit is high in any cycle.
//  Fairness: a continuously requesting client is granted within N_REQ grants.
//   - rr_ptr advances only on a grant and wraps from N_REQ-1 to 0.
//  Simultaneous events: a rsp_ready handshake and a new grant in the same RESP cycle are both taken, with no bubble.
//  Arithmetic: products are two's-complement, 7 bits. Only (-8)*(-8) overflows; rsp_ovf flags it, with no other correction.
//  op_cnt holds at 2^CNT_W-1 once it reaches that value.
// STRUCTURE
//  Package mul4_share_pkg holds:
//   - state enum {IDLE, CALC, RESP};
//   - constants OP_W=4, P_W=7, and NEG_MAX=4'sb1000.
//  One natural sub-module, mul4_rr_arb: a round-robin N_REQ arbiter.
//   - Inputs: req vector, rr_ptr, en. Outputs: one-hot grant, grant index.
//  The FSM, operand registers and counter live in this module, which also instantiates the shared 4x4 multiplier.
// TESTING
//  1. Single request: req0 a=3, b=-2 -> req_ready[0] at t0, rsp_valid at t0+2 with rsp_p=-6, rsp_id=0, rsp_ovf=0.
//  2. All 4 requesters valid continuously, rsp_ready=1:
//     -> grants in order 0,1,2,3,0; one rsp every 2 cycles; op_cnt=5 after 5 responses.
//  3. Backpressure: rsp_ready=0 for 5 cycles in RESP with a=-8, b=7.
//     -> rsp_p=-56 held stable; no req_ready asserted; completes when rsp_ready rises.
//  4. Overflow corner: a=-8, b=-8 -> rsp_p=7'b1000000 (-64), rsp_ovf=1. With a=-8, b=-7 -> rsp_p=56, rsp_ovf=0.
//  5. Reset asserted in CALC -> outputs 0 immediately (async). After release: state IDLE, rr_ptr=0, the re-presented request is served correctly.
//  6. Wrap/fairness: only req3 and req1 valid, rr_ptr=2 -> grant 3, then 1, then 3; no grant to idle requesters.

Source files
------------

// File: rtl/mul4_share_pkg.sv
// Shared types and constants for the 4x4 multiplier sharing controller.
// Imported by the arbiter and the controller top.
package mul4_share_pkg;

  localparam int OP_W = 4;
  localparam int P_W  = 7;

  localparam logic [OP_W-1:0] NEG_MAX = 4'sb1000;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    RESP
  } state_t;

  typedef struct packed {
    logic [OP_W-1:0] a;
    logic [OP_W-1:0] b;
    logic            ovf;
  } opnd_t;

endpackage

// File: rtl/mul4_rr_arb.sv
// Round-robin arbiter: first requester at or after ptr, wrapping.
// Grant is combinational and gated by en.
module mul4_rr_arb
  import mul4_share_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  input  logic             en,
  output logic [N_REQ-1:0] gnt,
  output logic [ID_W-1:0]  gnt_idx,
  output logic             any
);

  int idx;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    idx     = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (en && req[idx] && !any) begin
        any      = 1'b1;
        gnt[idx] = 1'b1;
        gnt_idx  = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/mul4_share_ctrl.sv
// Shares one registered 4x4 signed multiplier among N_REQ requesters,
// returning each product with its owner id over a valid/ready channel.
module mul4_share_ctrl
  import mul4_share_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2,
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_REQ-1:0]      req_valid,
  input  logic [4*N_REQ-1:0]    req_a,
  input  logic [4*N_REQ-1:0]    req_b,
  output logic [N_REQ-1:0]      req_ready,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ID_W-1:0]       rsp_id,
  output logic [P_W-1:0]        rsp_p,
  output logic                  rsp_ovf,
  output logic                  busy,
  output logic [CNT_W-1:0]      op_cnt
);

  state_t state, nxt;

  logic              arb_en;
  logic              any;
  logic [N_REQ-1:0]  gnt;
  logic [ID_W-1:0]   gnt_idx;
  logic [ID_W-1:0]   rr_ptr;
  logic              cnt_inc;
  logic              mul_en;

  opnd_t             sel;
  opnd_t             op;
  logic [ID_W-1:0]   op_id;
  logic signed [P_W-1:0] prod;

  mul4_rr_arb #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_arb (
    .req     (req_valid),
    .ptr     (rr_ptr),
    .en      (arb_en),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any     (any)
  );

  assign req_ready = gnt;
  assign busy      = (state != IDLE);
  assign rsp_valid = (state == RESP);
  assign mul_en    = (state == CALC);

  always_comb begin
    sel.a   = req_a[OP_W*gnt_idx +: OP_W];
    sel.b   = req_b[OP_W*gnt_idx +: OP_W];
    sel.ovf = (sel.a == NEG_MAX) && (sel.b == NEG_MAX);
  end

  always_comb begin
    nxt     = state;
    arb_en  = 1'b0;
    cnt_inc = 1'b0;
    unique case (state)
      IDLE: begin
        arb_en = rst_n;
        if (any) nxt = CALC;
      end
      CALC: nxt = RESP;
      RESP: begin
        if (rsp_ready) begin
          cnt_inc = 1'b1;
          arb_en  = rst_n;
          nxt     = any ? CALC : IDLE;
        end
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      rr_ptr <= '0;
      op     <= '0;
      op_id  <= '0;
      op_cnt <= '0;
    end else begin
      state <= nxt;
      if (any) begin
        op     <= sel;
        op_id  <= gnt_idx;
        rr_ptr <= (gnt_idx == ID_W'(N_REQ-1)) ? '0 : gnt_idx + 1'b1;
      end
      if (cnt_inc && !(&op_cnt)) op_cnt <= op_cnt + 1'b1;
    end
  end

  // 7-bit context keeps only the representable product bits.
  assign prod = $signed(op.a) * $signed(op.b);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_p   <= '0;
      rsp_id  <= '0;
      rsp_ovf <= 1'b0;
    end else if (mul_en) begin
      rsp_p   <= prod;
      rsp_id  <= op_id;
      rsp_ovf <= op.ovf;
    end
  end

endmodule

// File: tb/tb_mul4_share_ctrl.sv
// Directed self-checking bench for mul4_share_ctrl.
// Inputs change 1 time unit after posedge; outputs sampled off-edge.
module tb_mul4_share_ctrl;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [15:0] req_a;
  logic [15:0] req_b;
  logic [3:0]  req_ready;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_id;
  logic [6:0]  rsp_p;
  logic        rsp_ovf;
  logic        busy;
  logic [15:0] op_cnt;

  int nvec = 0;
  int nerr = 0;

  mul4_share_ctrl #(
    .N_REQ (4),
    .ID_W  (2),
    .CNT_W (16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_p     (rsp_p),
    .rsp_ovf   (rsp_ovf),
    .busy      (busy),
    .op_cnt    (op_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set(input int i, input logic [3:0] a,
                     input logic [3:0] b);
    req_valid[i]   = 1'b1;
    req_a[4*i +: 4] = a;
    req_b[4*i +: 4] = b;
  endtask

  int          seq2 [5] = '{0, 1, 2, 3, 0};
  logic [6:0]  prod2[4] = '{7'h02, 7'h77, 7'h31, 7'h08};
  int          seq6 [3] = '{3, 1, 3};
  logic [6:0]  prod6[3] = '{7'h77, 7'h7F, 7'h77};
  logic [3:0]  e;

  initial begin
    rst_n = 1'b0;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    rsp_ready = 1'b0;
    #3;
    chk("rst_ready", req_ready, 4'b0000);
    chk("rst_valid", rsp_valid, 1'b0);
    chk("rst_p", rsp_p, 7'h00);
    chk("rst_id", rsp_id, 2'd0);
    chk("rst_ovf", rsp_ovf, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_cnt", op_cnt, 16'd0);
    #9 rst_n = 1'b1;
    cyc();

    // single request: 3 * -2
    set(0, 4'h3, 4'hE);
    rsp_ready = 1'b1;
    #1 chk("t1_ready", req_ready, 4'b0001);
    cyc();
    req_valid = '0;
    #1;
    chk("t1_calc_ready", req_ready, 4'b0000);
    chk("t1_calc_busy", busy, 1'b1);
    chk("t1_calc_valid", rsp_valid, 1'b0);
    cyc();
    chk("t1_valid", rsp_valid, 1'b1);
    chk("t1_p", rsp_p, 7'h7A);
    chk("t1_id", rsp_id, 2'd0);
    chk("t1_ovf", rsp_ovf, 1'b0);
    cyc();
    chk("t1_idle_valid", rsp_valid, 1'b0);
    chk("t1_idle_busy", busy, 1'b0);
    chk("t1_cnt", op_cnt, 16'd1);

    // all four requesting, back-to-back
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    cyc();
    chk("t2_cnt0", op_cnt, 16'd0);
    set(0, 4'h1, 4'h2);
    set(1, 4'hD, 4'h3);
    set(2, 4'h7, 4'h7);
    set(3, 4'h8, 4'hF);
    for (int k = 0; k < 5; k++) begin
      #1;
      e = 4'b0001 << seq2[k];
      chk("t2_grant", req_ready, e);
      if (k > 0) begin
        chk("t2_rsp_valid", rsp_valid, 1'b1);
        chk("t2_rsp_id", rsp_id, seq2[k-1]);
        chk("t2_rsp_p", rsp_p, prod2[seq2[k-1]]);
      end
      cyc();
      chk("t2_calc_valid", rsp_valid, 1'b0);
      chk("t2_calc_ready", req_ready, 4'b0000);
      cyc();
    end
    chk("t2_last_valid", rsp_valid, 1'b1);
    chk("t2_last_id", rsp_id, 2'd0);
    chk("t2_last_p", rsp_p, 7'h02);
    req_valid = '0;
    cyc();
    chk("t2_cnt", op_cnt, 16'd5);
    chk("t2_idle", rsp_valid, 1'b0);

    // backpressure: -8 * 7 held while rsp_ready low
    rsp_ready = 1'b0;
    set(2, 4'h8, 4'h7);
    #1 chk("t3_grant", req_ready, 4'b0100);
    cyc();
    req_valid = '0;
    set(0, 4'h1, 4'h1);
    #1 chk("t3_calc_ready", req_ready, 4'b0000);
    cyc();
    for (int k = 0; k < 5; k++) begin
      chk("t3_hold_valid", rsp_valid, 1'b1);
      chk("t3_hold_p", rsp_p, 7'h48);
      chk("t3_hold_ready", req_ready, 4'b0000);
      cyc();
    end
    rsp_ready = 1'b1;
    #1;
    chk("t3_b2b_grant", req_ready, 4'b0001);
    chk("t3_b2b_p", rsp_p, 7'h48);
    chk("t3_b2b_id", rsp_id, 2'd2);
    cyc();
    req_valid = '0;
    chk("t3_cnt", op_cnt, 16'd6);
    cyc();
    chk("t3_next_p", rsp_p, 7'h01);
    chk("t3_next_id", rsp_id, 2'd0);
    cyc();
    chk("t3_cnt2", op_cnt, 16'd7);
    chk("t3_idle", rsp_valid, 1'b0);

    // overflow corner and its neighbour
    set(1, 4'h8, 4'h8);
    #1 chk("t4_grant", req_ready, 4'b0010);
    cyc();
    req_valid = '0;
    cyc();
    chk("t4_ovf_p", rsp_p, 7'h40);
    chk("t4_ovf", rsp_ovf, 1'b1);
    chk("t4_ovf_id", rsp_id, 2'd1);
    set(2, 4'h8, 4'h9);
    #1 chk("t4_b2b_grant", req_ready, 4'b0100);
    cyc();
    req_valid = '0;
    cyc();
    chk("t4_p", rsp_p, 7'h38);
    chk("t4_novf", rsp_ovf, 1'b0);
    chk("t4_id", rsp_id, 2'd2);
    cyc();
    chk("t4_cnt", op_cnt, 16'd9);

    // async reset while in CALC
    set(0, 4'h2, 4'h3);
    #1 chk("t5_grant", req_ready, 4'b0001);
    cyc();
    rst_n = 1'b0;
    #1;
    chk("t5_rst_busy", busy, 1'b0);
    chk("t5_rst_ready", req_ready, 4'b0000);
    chk("t5_rst_p", rsp_p, 7'h00);
    chk("t5_rst_id", rsp_id, 2'd0);
    chk("t5_rst_cnt", op_cnt, 16'd0);
    chk("t5_rst_valid", rsp_valid, 1'b0);
    #1 rst_n = 1'b1;
    set(2, 4'h1, 4'h1);
    #1 chk("t5_ptr0_grant", req_ready, 4'b0001);
    cyc();
    req_valid = '0;
    cyc();
    chk("t5_p", rsp_p, 7'h06);
    chk("t5_id", rsp_id, 2'd0);
    cyc();
    chk("t5_cnt", op_cnt, 16'd1);

    // wrap/fairness with only req3 and req1
    set(1, 4'h1, 4'hF);
    #1 chk("t6_pre_grant", req_ready, 4'b0010);
    cyc();
    req_valid = '0;
    cyc();
    chk("t6_pre_p", rsp_p, 7'h7F);
    chk("t6_pre_id", rsp_id, 2'd1);
    set(3, 4'h3, 4'hD);
    set(1, 4'h1, 4'hF);
    for (int k = 0; k < 3; k++) begin
      #1;
      e = 4'b0001 << seq6[k];
      chk("t6_grant", req_ready, e);
      if (k > 0) begin
        chk("t6_rsp_id", rsp_id, seq6[k-1]);
        chk("t6_rsp_p", rsp_p, prod6[k-1]);
      end
      cyc();
      chk("t6_calc_ready", req_ready, 4'b0000);
      cyc();
    end
    chk("t6_last_id", rsp_id, 2'd3);
    chk("t6_last_p", rsp_p, 7'h77);
    req_valid = '0;
    cyc();
    chk("t6_cnt", op_cnt, 16'd5);
    chk("t6_idle_busy", busy, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
